// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage program counter and instruction fetch sequencer
module pc_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h00000000,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    input  logic [ADDR_W-1:0] i_adder_result,
    output logic [ADDR_W-1:0] o_adder_in,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_instr,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic              o_instr_valid,
    output logic              o_halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic              hold;
    logic              redirect;
    logic              accept;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] redirect_pc;

    assign hold        = ~i_enable | i_stall;
    assign redirect    = i_jump | i_branch_taken;
    assign target      = i_jump ? i_jump_target : i_branch_target;
    // Targets are word-aligned; low two bits are dropped.
    assign redirect_pc = target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    assign accept      = i_imem_ack & ~hold & ~redirect;

    // Request is combinational off state so it falls with the async reset.
    assign o_imem_req  = (state == FETCH) & ~hold;
    assign o_adder_in  = o_pc;
    assign o_imem_addr = o_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_pc          <= RESET_PC;
            o_instr       <= '0;
            o_pc_plus4    <= '0;
            o_instr_valid <= 1'b0;
            o_halted      <= 1'b0;
        end else begin
            o_instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        o_pc <= redirect_pc;
                    end else if (accept) begin
                        o_instr       <= i_instr;
                        o_pc_plus4    <= i_adder_result;
                        o_instr_valid <= 1'b1;
                        // HALT still pulses valid so it travels down the pipe.
                        if (i_instr == HALT_WORD) begin
                            state    <= HALTED;
                            o_halted <= 1'b1;
                        end else begin
                            o_pc <= i_adder_result;
                        end
                    end
                end
                HALTED: begin
                    o_halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed-vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic [31:0] i_adder_result;
    logic [31:0] o_adder_in;
    logic [31:0] o_pc;
    logic [31:0] o_imem_addr;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [31:0] i_instr;
    logic [31:0] o_instr;
    logic [31:0] o_pc_plus4;
    logic        o_instr_valid;
    logic        o_halted;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_adder_result  (i_adder_result),
        .o_adder_in      (o_adder_in),
        .o_pc            (o_pc),
        .o_imem_addr     (o_imem_addr),
        .o_imem_req      (o_imem_req),
        .i_imem_ack      (i_imem_ack),
        .i_instr         (i_instr),
        .o_instr         (o_instr),
        .o_pc_plus4      (o_pc_plus4),
        .o_instr_valid   (o_instr_valid),
        .o_halted        (o_halted)
    );

    // External PC adder.
    assign i_adder_result = o_adder_in + 32'd4;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        i_stall = 1'b0;
        i_branch_taken = 1'b0;
        i_branch_target = '0;
        i_jump = 1'b0;
        i_jump_target = '0;
        i_imem_ack = 1'b0;
        i_instr = '0;
        step();
        step();
        check_vec("rst_pc", o_pc, 32'h0);
        check_vec("rst_instr", o_instr, 32'h0);
        check_vec("rst_pc4", o_pc_plus4, 32'h0);
        check_vec("rst_valid", {31'b0, o_instr_valid}, 32'h0);
        check_vec("rst_req", {31'b0, o_imem_req}, 32'h0);
        check_vec("rst_halted", {31'b0, o_halted}, 32'h0);

        // 1: sequential fetch with ack every cycle
        i_rst_n = 1'b1;
        i_enable = 1'b1;
        i_imem_ack = 1'b1;
        i_instr = 32'h20010005;
        check_vec("idle_req", {31'b0, o_imem_req}, 32'h0);
        step();
        check_vec("t1_fetch_pc", o_pc, 32'h0);
        check_vec("t1_fetch_req", {31'b0, o_imem_req}, 32'h1);
        check_vec("t1_addr", o_imem_addr, 32'h0);
        step();
        check_vec("t1_pc4", o_pc, 32'h4);
        check_vec("t1_instr0", o_instr, 32'h20010005);
        check_vec("t1_plus4_0", o_pc_plus4, 32'h4);
        check_vec("t1_valid0", {31'b0, o_instr_valid}, 32'h1);
        i_instr = 32'h20020006;
        step();
        check_vec("t1_pc8", o_pc, 32'h8);
        check_vec("t1_instr1", o_instr, 32'h20020006);
        check_vec("t1_plus4_1", o_pc_plus4, 32'h8);
        check_vec("t1_valid1", {31'b0, o_instr_valid}, 32'h1);

        // 2: stall at PC=8 with ack held high
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_vec("t2_req", {31'b0, o_imem_req}, 32'h0);
            step();
            check_vec("t2_pc", o_pc, 32'h8);
            check_vec("t2_valid", {31'b0, o_instr_valid}, 32'h0);
            check_vec("t2_instr", o_instr, 32'h20020006);
        end
        i_stall = 1'b0;
        i_instr = 32'h20030007;
        step();
        check_vec("t2_resume_pc", o_pc, 32'hC);
        check_vec("t2_resume_instr", o_instr, 32'h20030007);
        check_vec("t2_resume_pc4", o_pc_plus4, 32'hC);
        check_vec("t2_resume_valid", {31'b0, o_instr_valid}, 32'h1);

        // 3: branch with same-cycle ack, then branch+jump
        i_branch_taken = 1'b1;
        i_branch_target = 32'h00000042;
        i_instr = 32'hDEADBEEF;
        step();
        check_vec("t3_br_pc", o_pc, 32'h40);
        check_vec("t3_br_valid", {31'b0, o_instr_valid}, 32'h0);
        check_vec("t3_br_instr", o_instr, 32'h20030007);
        i_jump = 1'b1;
        i_jump_target = 32'h00000100;
        step();
        check_vec("t3_jmp_pc", o_pc, 32'h100);
        check_vec("t3_jmp_valid", {31'b0, o_instr_valid}, 32'h0);

        // 4: redirect to 0, then ack delayed two cycles
        i_branch_taken = 1'b0;
        i_jump_target = 32'h0;
        i_imem_ack = 1'b0;
        step();
        i_jump = 1'b0;
        check_vec("t4_pc0", o_pc, 32'h0);
        for (int k = 0; k < 2; k++) begin
            check_vec("t4_wait_req", {31'b0, o_imem_req}, 32'h1);
            step();
            check_vec("t4_wait_pc", o_pc, 32'h0);
            check_vec("t4_wait_valid", {31'b0, o_instr_valid}, 32'h0);
        end
        check_vec("t4_ack_req", {31'b0, o_imem_req}, 32'h1);
        i_imem_ack = 1'b1;
        i_instr = 32'h11110000;
        step();
        check_vec("t4_pc", o_pc, 32'h4);
        check_vec("t4_valid", {31'b0, o_instr_valid}, 32'h1);
        check_vec("t4_instr", o_instr, 32'h11110000);

        // 5: advance to 16, fetch HALT
        step();
        step();
        step();
        check_vec("t5_pc16", o_pc, 32'h10);
        i_instr = 32'hFFFFFFFF;
        step();
        check_vec("t5_valid", {31'b0, o_instr_valid}, 32'h1);
        check_vec("t5_instr", o_instr, 32'hFFFFFFFF);
        check_vec("t5_halted", {31'b0, o_halted}, 32'h1);
        check_vec("t5_pc", o_pc, 32'h10);
        check_vec("t5_req", {31'b0, o_imem_req}, 32'h0);
        i_branch_taken = 1'b1;
        i_branch_target = 32'h80;
        i_instr = 32'h22220000;
        step();
        check_vec("t5_ign_pc", o_pc, 32'h10);
        check_vec("t5_ign_valid", {31'b0, o_instr_valid}, 32'h0);
        check_vec("t5_ign_halted", {31'b0, o_halted}, 32'h1);
        i_branch_taken = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_vec("t5_rst_pc", o_pc, 32'h0);
        check_vec("t5_rst_halted", {31'b0, o_halted}, 32'h0);
        step();
        i_rst_n = 1'b1;
        step();
        check_vec("t5_refetch_req", {31'b0, o_imem_req}, 32'h1);

        // 6: jump to 0xFFFFFFFE (aligned to ...FC), then wrap
        i_jump = 1'b1;
        i_jump_target = 32'hFFFFFFFE;
        step();
        check_vec("t6_jmp_pc", o_pc, 32'hFFFFFFFC);
        check_vec("t6_jmp_valid", {31'b0, o_instr_valid}, 32'h0);
        i_jump = 1'b0;
        i_instr = 32'h33330000;
        step();
        check_vec("t6_wrap_pc", o_pc, 32'h0);
        check_vec("t6_wrap_pc4", o_pc_plus4, 32'h0);
        check_vec("t6_wrap_valid", {31'b0, o_instr_valid}, 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_vec("t6_async_valid", {31'b0, o_instr_valid}, 32'h0);
        check_vec("t6_async_req", {31'b0, o_imem_req}, 32'h0);
        check_vec("t6_async_instr", o_instr, 32'h0);
        check_vec("t6_async_pc4", o_pc_plus4, 32'h0);
        check_vec("t6_async_pc", o_pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
